// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths, the EXE-to-MEM bus layout and the
// layouts of the buses MEM drives toward WB and ID.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 87;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_FORWARD_WD   = 72;

  // Members are listed MSB first so a cast of the raw bus lands each field
  // on the bit positions EXE packs them at.
  typedef struct packed {
    logic [3:0]  mul_div_op;
    logic        mul_div_sign;
    logic [1:0]  addr_lo;
    logic        mem_we;
    logic        ld_w;
    logic        ld_b;
    logic        ld_bu;
    logic        ld_h;
    logic        ld_hu;
    logic        st_w;
    logic        st_b;
    logic        st_h;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic        load_block;
    logic [31:0] pc;
    logic [31:0] final_result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        valid;
  } ms_forward_t;

  typedef struct packed {
    logic ld_w;
    logic ld_b;
    logic ld_bu;
    logic ld_h;
    logic ld_hu;
  } ld_op_t;

  function automatic ld_op_t get_ld_op(input es_to_ms_t bus);
    get_ld_op = ld_op_t'({bus.ld_w, bus.ld_b, bus.ld_bu, bus.ld_h, bus.ld_hu});
  endfunction

  // Stores also wait for a response, so both directions count as memory ops.
  function automatic logic is_mem_op(input es_to_ms_t bus);
    is_mem_op = bus.res_from_mem | bus.mem_we;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load data extraction: picks the addressed byte/half of a 32-bit word and
// sign- or zero-extends it according to the load opcode.
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] src_i,
  input  logic [1:0]  addr_lo_i,
  input  ld_op_t      ld_op_i,
  output logic [31:0] value_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = src_i[7:0];
    unique case (addr_lo_i)
      2'b00: ld_byte = src_i[7:0];
      2'b01: ld_byte = src_i[15:8];
      2'b10: ld_byte = src_i[23:16];
      2'b11: ld_byte = src_i[31:24];
      default: ld_byte = src_i[7:0];
    endcase
  end

  assign ld_half = addr_lo_i[1] ? src_i[31:16] : src_i[15:0];

  // Non-load ops fall through to the raw word; the top ignores it for them.
  always_comb begin
    value_o = src_i;
    if (ld_op_i.ld_b) begin
      value_o = {{24{ld_byte[7]}}, ld_byte};
    end else if (ld_op_i.ld_bu) begin
      value_o = {24'h0, ld_byte};
    end else if (ld_op_i.ld_h) begin
      value_o = {{16{ld_half[15]}}, ld_half};
    end else if (ld_op_i.ld_hu) begin
      value_o = {16'h0, ld_half};
    end else if (ld_op_i.ld_w) begin
      value_o = src_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the in-order LoongArch pipeline: waits for data responses,
// buffers them across WB stalls, extends load data and forwards to ID.
// Optional macro MS_LOAD_FWD_EN lets ID bypass a load once its data is here.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FORWARD_WD-1:0]   ms_forward,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  logic        ms_valid_q, ms_valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q, buf_data_d;
  es_to_ms_t   ms_bus_q;

  logic        ms_mem_op;
  logic        ms_ready_go;
  logic        ms_handoff;
  logic        buf_capture;
  logic [31:0] load_src;
  logic [31:0] load_value;
  logic [31:0] final_result;
  logic        load_block;
  ms_to_ws_t   ws_bus;
  ms_forward_t fwd_bus;

  assign ms_mem_op   = is_mem_op(ms_bus_q);
  assign ms_ready_go = !ms_mem_op | data_sram_data_ok | buf_valid_q;
  assign ms_allowin  = !ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_handoff  = ms_to_ws_valid & ws_allowin;

  // Only park the response when it cannot leave this cycle; stray data_ok
  // with no memory op in MEM is dropped.
  assign buf_capture = ms_valid_q & ms_mem_op & data_sram_data_ok
                     & !buf_valid_q & !ms_handoff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= 32'h0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_bus_q <= es_to_ms_t'(es_to_ms_bus);
    end
  end

  // Handoff to WB retires the instruction and its buffered response together.
  always_comb begin
    ms_valid_d  = ms_valid_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (ms_handoff) begin
      buf_valid_d = 1'b0;
    end else if (buf_capture) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
  end

  assign load_src = buf_valid_q ? buf_data_q : data_sram_rdata;

  mem_stage_load_extend u_load_extend (
    .src_i     (load_src),
    .addr_lo_i (ms_bus_q.addr_lo),
    .ld_op_i   (get_ld_op(ms_bus_q)),
    .value_o   (load_value)
  );

  assign final_result = ms_bus_q.res_from_mem ? load_value : ms_bus_q.alu_result;

`ifdef MS_LOAD_FWD_EN
  assign load_block = ms_valid_q & ms_bus_q.res_from_mem
                    & !(data_sram_data_ok | buf_valid_q);
`else
  assign load_block = ms_valid_q & ms_bus_q.res_from_mem;
`endif

  always_comb begin
    ws_bus.gr_we        = ms_bus_q.gr_we;
    ws_bus.dest         = ms_bus_q.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = ms_bus_q.pc;
  end

  always_comb begin
    fwd_bus.load_block   = load_block;
    fwd_bus.pc           = ms_bus_q.pc;
    fwd_bus.final_result = final_result;
    fwd_bus.dest         = ms_bus_q.dest;
    fwd_bus.gr_we        = ms_bus_q.gr_we;
    fwd_bus.valid        = ms_valid_q;
  end

  assign ms_to_ws_bus = ws_bus;
  assign ms_forward   = fwd_bus;

  // Multiply/divide and store-width fields are consumed by later stages only.
  logic unused_bus_fields;
  assign unused_bus_fields = ^{ms_bus_q.mul_div_op, ms_bus_q.mul_div_sign,
                               ms_bus_q.st_w, ms_bus_q.st_b, ms_bus_q.st_h};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instruction traffic checked against an instruction-level reference model.
module tb_mem_stage;

  localparam int K_ALU  = 0;
  localparam int K_LDB  = 1;
  localparam int K_LDBU = 2;
  localparam int K_LDH  = 3;
  localparam int K_LDHU = 4;
  localparam int K_LDW  = 5;
  localparam int K_STW  = 6;
  localparam int K_STB  = 7;
  localparam int NUM_RANDOM = 150;

  typedef struct {
    int          kind;
    logic [1:0]  addr;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  dest;
    logic [4:0]  md;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [86:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [71:0] ms_forward;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_forward        (ms_forward),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  function automatic logic isLoad(input int k);
    return (k >= K_LDB) && (k <= K_LDW);
  endfunction

  function automatic logic isStore(input int k);
    return (k == K_STW) || (k == K_STB);
  endfunction

  function automatic logic [86:0] makeBus(input instr_t t);
    logic [86:0] b;
    b          = '0;
    b[31:0]    = t.pc;
    b[63:32]   = t.alu;
    b[68:64]   = t.dest;
    b[69]      = !isStore(t.kind);
    b[70]      = isLoad(t.kind);
    b[72]      = (t.kind == K_STB);
    b[73]      = (t.kind == K_STW);
    b[74]      = (t.kind == K_LDHU);
    b[75]      = (t.kind == K_LDH);
    b[76]      = (t.kind == K_LDBU);
    b[77]      = (t.kind == K_LDB);
    b[78]      = (t.kind == K_LDW);
    b[79]      = isStore(t.kind);
    b[81:80]   = t.addr;
    b[86:82]   = t.md;
    return b;
  endfunction

  // Architectural result: the loaded value for loads, otherwise the ALU value.
  function automatic logic [31:0] refResult(input instr_t t);
    logic [31:0] v;
    case (t.kind)
      K_LDB, K_LDBU: begin
        v = (t.data >> (8 * t.addr)) & 32'hFF;
        if (t.kind == K_LDB && v >= 32'd128) v = v - 32'd256;
      end
      K_LDH, K_LDHU: begin
        v = (t.data >> (16 * t.addr[1])) & 32'hFFFF;
        if (t.kind == K_LDH && v >= 32'd32768) v = v - 32'd65536;
      end
      K_LDW:   v = t.data;
      default: v = t.alu;
    endcase
    return v;
  endfunction

  function automatic logic [69:0] expWs(input instr_t t);
    return {!isStore(t.kind), t.dest, refResult(t), t.pc};
  endfunction

  function automatic instr_t mkInstr(input int kind, input logic [1:0] addr,
                                     input logic [31:0] alu, input logic [31:0] pc,
                                     input logic [4:0] dest);
    instr_t t;
    t.kind = kind;
    t.addr = addr;
    t.alu  = alu;
    t.pc   = pc;
    t.data = 32'h0;
    t.dest = dest;
    t.md   = 5'h0;
    return t;
  endfunction

  function automatic instr_t randInstr(input int idx);
    instr_t t;
    logic [31:0] a;
    t.kind = int'($urandom_range(0, 7));
    t.addr = 2'($urandom_range(0, 3));
    if (t.kind == K_LDH || t.kind == K_LDHU) t.addr[0] = 1'b0;
    if (t.kind == K_LDW || t.kind == K_STW) t.addr = 2'b00;
    a = $urandom;
    a[1:0] = t.addr;
    t.alu  = a;
    t.pc   = 32'h1c001000 + 32'(4 * idx);
    t.data = $urandom;
    t.dest = 5'($urandom_range(1, 31));
    t.md   = 5'($urandom_range(0, 31));
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic esv, input logic [86:0] bus, input logic wsa,
                               input logic dok, input logic [31:0] rd);
    es_to_ms_valid    = esv;
    es_to_ms_bus      = bus;
    ws_allowin        = wsa;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  instr_t      t;
  instr_t      pend;
  instr_t      slot;
  logic [86:0] b;
  logic        pendV, slotV, slotResp, wsa, dok, expReady, expAllow, expBlock;
  logic [31:0] rd;
  int          slotDelay, sent, cyc, dutFires;

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0);
    checkOutput("reset ms_allowin", 72'(ms_allowin), 72'(1'b1));
    checkOutput("reset ms_to_ws_valid", 72'(ms_to_ws_valid), 72'(1'b0));
    checkOutput("reset fwd valid", 72'(ms_forward[0]), 72'(1'b0));
    checkOutput("reset load_block", 72'(ms_forward[71]), 72'(1'b0));

    // ALU op passes straight through
    t = mkInstr(K_ALU, 2'b00, 32'h12345678, 32'h1c000000, 5'd5);
    b = makeBus(t);
    applyStimulus(1'b1, b, 1'b1, 1'b0, 32'h0);
    checkOutput("alu accept", 72'(ms_allowin), 72'(1'b1));
    tick();
    applyStimulus(1'b0, b, 1'b1, 1'b0, 32'hA5A5A5A5);
    checkOutput("alu valid", 72'(ms_to_ws_valid), 72'(1'b1));
    checkOutput("alu ws bus", 72'(ms_to_ws_bus), 72'({1'b1, 5'd5, 32'h12345678, 32'h1c000000}));
    checkOutput("alu fwd", 72'(ms_forward), {1'b0, 32'h1c000000, 32'h12345678, 5'd5, 1'b1, 1'b1});
    tick();
    applyStimulus(1'b0, b, 1'b1, 1'b0, 32'h0);
    checkOutput("alu retired", 72'(ms_to_ws_valid), 72'(1'b0));

    // ld_b / ld_bu with zero-cycle pass-through of the response
    for (int k = 0; k < 2; k++) begin
      t = mkInstr((k == 0) ? K_LDB : K_LDBU, 2'b11, 32'h1c008003, 32'h1c000004, 5'd6);
      b = makeBus(t);
      applyStimulus(1'b1, b, 1'b1, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b0, b, 1'b1, 1'b0, 32'h0);
      checkOutput("ldb waiting valid", 72'(ms_to_ws_valid), 72'(1'b0));
      checkOutput("ldb waiting allowin", 72'(ms_allowin), 72'(1'b0));
      checkOutput("ldb load_block", 72'(ms_forward[71]), 72'(1'b1));
      applyStimulus(1'b0, b, 1'b1, 1'b1, 32'h80FFFFFF);
      checkOutput("ldb pass valid", 72'(ms_to_ws_valid), 72'(1'b1));
      checkOutput("ldb pass allowin", 72'(ms_allowin), 72'(1'b1));
      checkOutput("ldb result", 72'(ms_to_ws_bus[63:32]),
                  72'((k == 0) ? 32'hFFFFFF80 : 32'h00000080));
      tick();
      applyStimulus(1'b0, b, 1'b1, 1'b0, 32'h0);
      checkOutput("ldb retired", 72'(ms_to_ws_valid), 72'(1'b0));
    end

    // ld_h response arrives while WB stalls, so it must be held in the buffer
    t = mkInstr(K_LDH, 2'b10, 32'h1c008002, 32'h1c000008, 5'd7);
    b = makeBus(t);
    applyStimulus(1'b1, b, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, b, 1'b0, 1'b1, 32'h9ABC1234);
    checkOutput("ldh dok valid", 72'(ms_to_ws_valid), 72'(1'b1));
    checkOutput("ldh dok allowin", 72'(ms_allowin), 72'(1'b0));
    tick();
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b0, b, 1'b0, 1'b0, 32'h5555AAAA);
      checkOutput("ldh held valid", 72'(ms_to_ws_valid), 72'(1'b1));
      checkOutput("ldh held allowin", 72'(ms_allowin), 72'(1'b0));
      checkOutput("ldh held result", 72'(ms_to_ws_bus[63:32]), 72'(32'hFFFF9ABC));
      tick();
    end
    applyStimulus(1'b0, b, 1'b1, 1'b0, 32'h5555AAAA);
    checkOutput("ldh release allowin", 72'(ms_allowin), 72'(1'b1));
    checkOutput("ldh release result", 72'(ms_to_ws_bus[63:32]), 72'(32'hFFFF9ABC));
    tick();

    // st_w with a delayed response; also shows the buffer was cleared
    t = mkInstr(K_STW, 2'b00, 32'h1c009000, 32'h1c00000c, 5'd0);
    b = makeBus(t);
    applyStimulus(1'b1, b, 1'b1, 1'b0, 32'h0);
    tick();
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b0, b, 1'b1, 1'b0, 32'h0BADF00D);
      checkOutput("stw wait valid", 72'(ms_to_ws_valid), 72'(1'b0));
      checkOutput("stw wait allowin", 72'(ms_allowin), 72'(1'b0));
      tick();
    end
    applyStimulus(1'b0, b, 1'b1, 1'b1, 32'h0BADF00D);
    checkOutput("stw done valid", 72'(ms_to_ws_valid), 72'(1'b1));
    checkOutput("stw ws bus", 72'(ms_to_ws_bus), 72'({1'b0, 5'd0, 32'h1c009000, 32'h1c00000c}));
    tick();

    // Reset while a load is pending, then a stray response
    t = mkInstr(K_LDW, 2'b00, 32'h1c00a000, 32'h1c000010, 5'd9);
    b = makeBus(t);
    applyStimulus(1'b1, b, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, b, 1'b1, 1'b0, 32'h0);
    checkOutput("ldw pending load_block", 72'(ms_forward[71]), 72'(1'b1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, b, 1'b1, 1'b0, 32'h0);
    checkOutput("midreset fwd valid", 72'(ms_forward[0]), 72'(1'b0));
    checkOutput("midreset valid", 72'(ms_to_ws_valid), 72'(1'b0));
    checkOutput("midreset allowin", 72'(ms_allowin), 72'(1'b1));
    $display("[TB] note: driving data_ok with no instruction in MEM; it must be ignored");
    applyStimulus(1'b0, b, 1'b1, 1'b1, 32'h11112222);
    checkOutput("stray dok valid", 72'(ms_to_ws_valid), 72'(1'b0));
    tick();

    // A fresh load must not see the stray response in the buffer
    t = mkInstr(K_LDW, 2'b00, 32'h1c00b000, 32'h1c000014, 5'd10);
    b = makeBus(t);
    applyStimulus(1'b1, b, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, b, 1'b0, 1'b0, 32'h0);
    checkOutput("no stale capture", 72'(ms_to_ws_valid), 72'(1'b0));
    checkOutput("ldw load_block", 72'(ms_forward[71]), 72'(1'b1));
    for (int s = 0; s < 2; s++) begin
      applyStimulus(1'b0, b, 1'b0, (s == 0), (s == 0) ? 32'hDEADBEEF : 32'h0);
`ifdef MS_LOAD_FWD_EN
      checkOutput("ldw data load_block", 72'(ms_forward[71]), 72'(1'b0));
      checkOutput("ldw fwd result", 72'(ms_forward[38:7]), 72'(32'hDEADBEEF));
`else
      checkOutput("ldw data load_block", 72'(ms_forward[71]), 72'(1'b1));
`endif
      checkOutput("ldw data valid", 72'(ms_to_ws_valid), 72'(1'b1));
      checkOutput("ldw data allowin", 72'(ms_allowin), 72'(1'b0));
      if (s == 0) tick();
    end
    applyStimulus(1'b0, b, 1'b1, 1'b0, 32'h0);
    checkOutput("ldw ws result", 72'(ms_to_ws_bus[63:32]), 72'(32'hDEADBEEF));
    tick();

    // Random traffic against the instruction-level model
    pend      = randInstr(0);
    slot      = pend;
    pendV     = 1'b0;
    slotV     = 1'b0;
    slotResp  = 1'b0;
    slotDelay = 0;
    sent      = 0;
    cyc       = 0;
    dutFires  = 0;
    while ((sent < NUM_RANDOM || pendV || slotV) && cyc < 4000) begin
      cyc++;
      if (!pendV && sent < NUM_RANDOM && $urandom_range(0, 2) != 0) begin
        pend  = randInstr(sent);
        pendV = 1'b1;
        sent++;
      end
      wsa = ($urandom_range(0, 3) != 0);
      dok = 1'b0;
      rd  = $urandom;
      if (slotV && (isLoad(slot.kind) || isStore(slot.kind)) && !slotResp) begin
        if (slotDelay == 0) begin
          dok = 1'b1;
          rd  = slot.data;
        end else begin
          slotDelay--;
        end
      end
      applyStimulus(pendV, makeBus(pend), wsa, dok, rd);
      if (dok) slotResp = 1'b1;
      expReady = slotV && (!(isLoad(slot.kind) || isStore(slot.kind)) || slotResp);
      expAllow = !slotV || (expReady && wsa);
`ifdef MS_LOAD_FWD_EN
      expBlock = slotV && isLoad(slot.kind) && !slotResp;
`else
      expBlock = slotV && isLoad(slot.kind);
`endif
      checkOutput("rnd ms_to_ws_valid", 72'(ms_to_ws_valid), 72'(expReady));
      checkOutput("rnd ms_allowin", 72'(ms_allowin), 72'(expAllow));
      checkOutput("rnd fwd valid", 72'(ms_forward[0]), 72'(slotV));
      checkOutput("rnd load_block", 72'(ms_forward[71]), 72'(expBlock));
      if (ms_to_ws_valid && wsa) dutFires++;
      if (expReady && wsa) begin
        checkOutput("rnd ws bus", 72'(ms_to_ws_bus), 72'(expWs(slot)));
        slotV = 1'b0;
      end
      if (pendV && expAllow) begin
        slot      = pend;
        slotV     = 1'b1;
        slotResp  = 1'b0;
        slotDelay = int'($urandom_range(0, 3));
        pendV     = 1'b0;
      end
      tick();
    end
    checkOutput("rnd retired count", 72'(dutFires), 72'(NUM_RANDOM));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth stage of the 5-stage in-order LoongArch pipeline, between EXE and WB.
- Accepts the EXE-to-MEM bus and waits for `data_sram_data_ok` on any memory op that EXE issued. Store responses are awaited too.
- Captures the returned data in a one-entry buffer, then extracts and extends load data.
- Forwards the result and hazard status to ID.

Parameters:
- None. All bus widths come from the shared header: ES_TO_MS_BUS_WD=87, MS_TO_WS_BUS_WD=70, MS_FORWARD_WD=72.

Ports:
- clk  in  1  clock; all state updates on posedge clk
- reset  in  1  synchronous, active-high reset
- ws_allowin  in  1  WB can accept this cycle
- ms_allowin  out  1  MEM can accept from EXE
- es_to_ms_valid  in  1  EXE bus valid
- es_to_ms_bus  in  87  EXE-to-MEM bus:
  - pc[31:0], alu_result[63:32], dest[68:64], gr_we[69], res_from_mem[70]
  - st_h[71], st_b[72], st_w[73], ld_hu[74], ld_h[75], ld_bu[76], ld_b[77], ld_w[78]
  - mem_we[79], addr_lo[81:80], mul_div_sign[82], mul_div_op[86:83]
- ms_to_ws_valid  out  1  bus to WB valid
- ms_to_ws_bus  out  70  pc[31:0], final_result[63:32], dest[68:64], gr_we[69]
- ms_forward  out  72  valid[0], gr_we[1], dest[6:2], final_result[38:7], pc[70:39], load_block[71]
- data_sram_data_ok  in  1  data response for the oldest outstanding request
- data_sram_rdata  in  32  response data, meaningful only with data_ok

Behaviour:
- Registers:
  - ms_valid; reset 0.
  - ms_bus_r: 87 bits, loaded when es_to_ms_valid && ms_allowin; not reset.
  - buf_valid; reset 0.
  - buf_data: 32 bits; reset 0.
- Valid pipelining: when ms_allowin, ms_valid <= es_to_ms_valid.
- ms_mem_op = res_from_mem | mem_we. EXE asserts req only for these ops, so each valid mem-op instruction has exactly one response.
- Handshake:
  - ms_ready_go = !ms_mem_op | data_sram_data_ok | buf_valid.
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go.
  - Combinational data_ok path: data_ok and ws_allowin in the same cycle means zero-cycle pass-through, with rdata used directly.
- Response buffer:
  - Capture: ms_valid & ms_mem_op & data_sram_data_ok & !buf_valid & !(ms_to_ws_valid & ws_allowin). Then buf_valid <= 1, buf_data <= rdata.
  - Clear: buf_valid <= 0 when ms_to_ws_valid & ws_allowin. Clear wins over capture.
  - Ignore data_ok when !ms_valid or !ms_mem_op; no state change. This is an illegal stimulus; the bench flags it.
- Load data extraction:
  - src = buf_valid ? buf_data : data_sram_rdata.
  - byte = src >> {addr_lo,3'b0}; half = addr_lo[1] ? src[31:16] : src[15:0].
  - ld_b: sign-extend byte[7:0]; ld_bu: zero-extend it.
  - ld_h: sign-extend half; ld_hu: zero-extend it.
  - ld_w: src.
- final_result = res_from_mem ? load_value : alu_result.
- Stores: the result is alu_result. gr_we comes from the bus; a store has gr_we=0.
- Forward: valid = ms_valid. The other fields come from ms_bus_r and final_result.
- Reset mid-operation: ms_valid=0 and buf_valid=0 next cycle. Pending responses are dropped; the bus slave is reset together with the core.
- WB stall with data held: instruction and buf_data stay stable until ws_allowin. EXE is blocked via ms_allowin=0.

Optional Feature:
- Macro: MS_LOAD_FWD_EN.
- Defined: load_block = ms_valid & res_from_mem & !(data_ok | buf_valid). Once data is present, ID may bypass the extended load value from MEM.
- Undefined: load_block = ms_valid & res_from_mem. ID stalls until the load reaches WB, and final_result in ms_forward is don't-care for loads.

Decomposition:
- Shared header myCPU.h holds:
  - ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, MS_FORWARD_WD
  - bus field bit-position constants
  - MS_LOAD_FWD_EN
- Sub-module load_extend: combinational; inputs src[31:0], addr_lo, 5 load-op bits; output value[31:0].

Test Plan:
- ALU op, add result 0x12345678, ws_allowin=1 -> ms_to_ws_valid same cycle as ms_valid; final_result 0x12345678; no buffer capture.
- ld_b, addr_lo=2'b11, data_ok with rdata 0x80FFFFFF, ws_allowin=1 -> final_result 0xFFFFFF80, passed the same cycle. ld_bu with the same data -> 0x00000080.
- ld_h, addr_lo=2'b10, data_ok rdata 0x9ABC1234 while ws_allowin=0 -> buf_valid=1 and ms_allowin=0. Stall 3 cycles, then ws_allowin=1 -> final_result 0xFFFF9ABC, buf_valid=0 next cycle.
- st_w with data_ok delayed 4 cycles -> ms_to_ws_valid=0 and ms_allowin=0 until data_ok; then gr_we=0 passed through.
- ld_w pending, then reset asserted for 1 cycle -> ms_valid=0 and buf_valid=0. A later data_ok is ignored.
- ld_w pending, no data_ok -> load_block=1. After data_ok with rdata 0xDEADBEEF, ws_allowin=0:
  - with MS_LOAD_FWD_EN: load_block=0 and forward result 0xDEADBEEF.
  - without it: load_block stays 1.
